cw12_encoder_channel: RTL and testbench

- Upstream stage of the 12-bit minimum-distance decoder.
- Accepts a 4-bit message over a valid/ready handshake and encodes it into the linear (12,4) codeword.
- Optionally corrupts the codeword with a fixed mask or an LFSR-driven random error pattern.
- Holds the result on a 12-bit bus for a programmable number of cycles, because the decoder is multi-cycle and has no input handshake.

---
 rtl/cw12_pkg.sv | 41 ++++
 rtl/cw12_encoder_channel_if.sv | 24 ++
 rtl/cw12_lfsr16.sv | 18 +
 rtl/cw12_encoder_channel.sv | 109 ++++++++++
 tb/tb_cw12_encoder_channel.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cw12_pkg.sv
// Shared constants for the (12,4) encoder channel: generator rows, codeword
// table, FSM state and error-mode encodings, LFSR taps.
package cw12_pkg;

  typedef logic [11:0] cw_t;

  localparam cw_t GEN_ROW [4] = '{12'h03B, 12'h0EC, 12'h3B0, 12'hEC0};

  // Precomputed XOR-of-rows for every message; cw[j] matches the decoder's table.
  localparam cw_t CW_TABLE [16] = '{
    12'h000, 12'h03B, 12'h0EC, 12'h0D7,
    12'h3B0, 12'h38B, 12'h35C, 12'h367,
    12'hEC0, 12'hEFB, 12'hE2C, 12'hE17,
    12'hD70, 12'hD4B, 12'hD9C, 12'hDA7
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_INJECT = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_MASK = 2'b01,
    ERR_RAND = 2'b10,
    ERR_RSVD = 2'b11
  } err_mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic cw_t encode(input logic [3:0] m);
    cw_t r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r = r ^ GEN_ROW[i];
    return r;
  endfunction

endpackage

// File: rtl/cw12_encoder_channel_if.sv
// Message handshake in, held codeword bus out. master = message source and
// codeword consumer, slave = the encoder channel.
interface cw12_encoder_channel_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [3:0]  msg;
  logic [1:0]  err_mode;
  logic [11:0] err_mask;
  logic [11:0] tx_bits;
  logic [11:0] tx_clean;
  logic [3:0]  tx_msg;
  logic        tx_valid;
  logic [3:0]  tx_err_weight;

  modport master (
    output msg_valid, msg, err_mode, err_mask,
    input  msg_ready, tx_bits, tx_clean, tx_msg, tx_valid, tx_err_weight
  );

  modport slave (
    input  msg_valid, msg, err_mode, err_mask,
    output msg_ready, tx_bits, tx_clean, tx_msg, tx_valid, tx_err_weight
  );
endinterface

// File: rtl/cw12_lfsr16.sv
// 16-bit right-shifting Galois LFSR; reloads SEED on reset, steps when en.
module cw12_lfsr16
  import cw12_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= SEED;
    else if (en) state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/cw12_encoder_channel.sv
// Encodes a 4-bit message into the (12,4) codeword, optionally corrupts it,
// and holds it for HOLD_CYCLES so the handshake-less decoder can consume it.
module cw12_encoder_channel
  import cw12_pkg::*;
#(
  parameter int          HOLD_CYCLES = 64,
  parameter int          MAX_ERR     = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cw12_encoder_channel_if.slave   bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] FLIP_LAST = 2'(MAX_ERR - 1);

  state_e      state;
  logic [3:0]  msg_q;
  err_mode_e   mode_q;
  logic [11:0] mask_q;
  logic [11:0] tx_bits_q;
  logic [11:0] tx_clean_q;
  logic [3:0]  tx_msg_q;
  logic        tx_valid_q;
  logic [7:0]  hold_cnt;
  logic [1:0]  flip_cnt;
  logic [15:0] lfsr;

  cw12_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_INJECT),
    .state (lfsr)
  );

  // Positions 12..15 read as "already flipped" so out-of-range picks retry.
  logic [15:0] diff16;
  logic [3:0]  pos;
  logic        pos_ok;
  logic [11:0] flip_vec;
  assign diff16   = {4'hF, tx_bits_q ^ tx_clean_q};
  assign pos      = lfsr[3:0];
  assign pos_ok   = ~diff16[pos];
  assign flip_vec = 12'(16'h0001 << pos);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      msg_q      <= '0;
      mode_q     <= ERR_NONE;
      mask_q     <= '0;
      tx_bits_q  <= '0;
      tx_clean_q <= '0;
      tx_msg_q   <= '0;
      tx_valid_q <= 1'b0;
      hold_cnt   <= '0;
      flip_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.msg_valid) begin
          msg_q  <= bus.msg;
          mode_q <= err_mode_e'(bus.err_mode);
          mask_q <= bus.err_mask;
          state  <= ST_ENCODE;
        end
        ST_ENCODE: begin
          tx_clean_q <= CW_TABLE[msg_q];
          tx_msg_q   <= msg_q;
          tx_bits_q  <= CW_TABLE[msg_q] ^ ((mode_q == ERR_MASK) ? mask_q : 12'h000);
          if (mode_q == ERR_RAND && MAX_ERR > 0) begin
            flip_cnt <= '0;
            state    <= ST_INJECT;
          end else begin
            hold_cnt   <= '0;
            tx_valid_q <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_INJECT: if (pos_ok) begin
          tx_bits_q <= tx_bits_q ^ flip_vec;
          flip_cnt  <= flip_cnt + 2'd1;
          if (flip_cnt == FLIP_LAST) begin
            hold_cnt   <= '0;
            tx_valid_q <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            tx_valid_q <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.msg_ready     = (state == ST_IDLE);
  assign bus.tx_bits       = tx_bits_q;
  assign bus.tx_clean      = tx_clean_q;
  assign bus.tx_msg        = tx_msg_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.tx_err_weight = 4'($countones(tx_bits_q ^ tx_clean_q));

endmodule

// File: tb/tb_cw12_encoder_channel.sv
// Self-checking bench for cw12_encoder_channel: directed sequence plus
// randomized messages against a bench-side codeword/error-pattern model.
module tb_cw12_encoder_channel;

  localparam int          HOLD  = 64;
  localparam int          HOLD4 = 4;
  localparam int          MAXE  = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  localparam logic [11:0] ROW0 = 12'b000000111011;
  localparam logic [11:0] ROW1 = 12'b000011101100;
  localparam logic [11:0] ROW2 = 12'b001110110000;
  localparam logic [11:0] ROW3 = 12'b111011000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cw12_encoder_channel_if bus();
  cw12_encoder_channel_if bus4();

  cw12_encoder_channel #(.HOLD_CYCLES(HOLD), .MAX_ERR(MAXE), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  cw12_encoder_channel #(.HOLD_CYCLES(HOLD4), .MAX_ERR(MAXE), .LFSR_SEED(SEED)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  int errors = 0;
  int checks = 0;
  logic [15:0] mlfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_enc(input logic [3:0] m);
    logic [11:0] r;
    r = 12'h000;
    if (m[0]) r = r ^ ROW0;
    if (m[1]) r = r ^ ROW1;
    if (m[2]) r = r ^ ROW2;
    if (m[3]) r = r ^ ROW3;
    return r;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Draws positions from the sequence until MAXE distinct in-range bits are chosen.
  task automatic ref_rand(output logic [11:0] pat, output int steps);
    int n;
    int p;
    pat = 12'h000; steps = 0; n = 0;
    while (n < MAXE) begin
      p = int'(mlfsr[3:0]);
      if (p < 12 && !pat[p]) begin
        pat[p] = 1'b1;
        n++;
      end
      mlfsr = lstep(mlfsr);
      steps++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [1:0] mode, input logic [11:0] mask,
                      output int lat);
    int g;
    g = 0;
    while (!bus.msg_ready && g < 500) begin tick(); g++; end
    chk("ready_wait", 32'(bus.msg_ready), 32'd1);
    bus.msg = m; bus.err_mode = mode; bus.err_mask = mask; bus.msg_valid = 1'b1;
    tick();
    bus.msg_valid = 1'b0;
    lat = 0;
    while (!bus.tx_valid && lat < 300) begin tick(); lat++; end
  endtask

  task automatic hold_len(output int n);
    n = 0;
    while (bus.tx_valid && n < 400) begin n++; tick(); end
  endtask

  initial begin
    int          lat, n, steps, md, d, nhs, low;
    int          hs [2];
    logic [3:0]  m;
    logic [11:0] pat, first_pat, between;
    logic [11:0] seen [16];

    bus.msg_valid = 1'b0; bus.msg = '0; bus.err_mode = '0; bus.err_mask = '0;
    bus4.msg_valid = 1'b0; bus4.msg = '0; bus4.err_mode = '0; bus4.err_mask = '0;
    mlfsr = SEED;

    #12;
    chk("rst_ready", 32'(bus.msg_ready), 32'd1);
    chk("rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_bits", 32'(bus.tx_bits), 32'd0);
    chk("rst_clean", 32'(bus.tx_clean), 32'd0);
    chk("rst_msg", 32'(bus.tx_msg), 32'd0);
    chk("rst_wt", 32'(bus.tx_err_weight), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Mode none, msg B: latency, value and hold window length
    send(4'hB, 2'b00, 12'h000, lat);
    chk("none_lat", 32'(lat), 32'd1);
    chk("none_bits", 32'(bus.tx_bits), 32'(12'b111000010111));
    chk("none_clean", 32'(bus.tx_clean), 32'(12'b111000010111));
    chk("none_msg", 32'(bus.tx_msg), 32'hB);
    chk("none_wt", 32'(bus.tx_err_weight), 32'd0);
    hold_len(n);
    chk("hold_len", 32'(n), 32'(HOLD));
    chk("idle_stable_bits", 32'(bus.tx_bits), 32'(12'b111000010111));
    chk("idle_valid", 32'(bus.tx_valid), 32'd0);

    // Reserved mode behaves as none
    send(4'h6, 2'b11, 12'hFFF, lat);
    chk("rsvd_lat", 32'(lat), 32'd1);
    chk("rsvd_bits", 32'(bus.tx_bits), 32'(ref_enc(4'h6)));
    chk("rsvd_wt", 32'(bus.tx_err_weight), 32'd0);

    // Mask mode
    send(4'h5, 2'b01, 12'h001, lat);
    chk("mask_lat", 32'(lat), 32'd1);
    chk("mask_clean", 32'(bus.tx_clean), 32'(12'b001110001011));
    chk("mask_bits", 32'(bus.tx_bits), 32'(12'b001110001010));
    chk("mask_wt", 32'(bus.tx_err_weight), 32'd1);

    // Exhaustive sweep, then code distance from the observed codewords
    for (int j = 0; j < 16; j++) begin
      send(4'(j), 2'b00, 12'h000, lat);
      chk("sweep_clean", 32'(bus.tx_clean), 32'(ref_enc(4'(j))));
      seen[j] = bus.tx_clean;
    end
    md = 99;
    for (int a = 0; a < 16; a++)
      for (int b = a + 1; b < 16; b++) begin
        d = $countones(seen[a] ^ seen[b]);
        if (d < md) md = d;
      end
    chk("min_dist", 32'(md), 32'd5);

    // Random mode: exact error pattern and latency from the model
    first_pat = 12'h000;
    for (int k = 0; k < 200; k++) begin
      m = 4'($urandom_range(0, 15));
      ref_rand(pat, steps);
      if (k == 0) first_pat = pat;
      send(m, 2'b10, 12'($urandom), lat);
      chk("rnd_lat", 32'(lat), 32'(1 + steps));
      chk("rnd_clean", 32'(bus.tx_clean), 32'(ref_enc(m)));
      chk("rnd_pat", 32'(bus.tx_bits ^ bus.tx_clean), 32'(pat));
      chk("rnd_wt", 32'(bus.tx_err_weight), 32'(MAXE));
    end

    // Asynchronous reset in mid-HOLD, then the sequence must restart from the seed
    ref_rand(pat, steps);
    send(4'h7, 2'b10, 12'h000, lat);
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.tx_valid), 32'd0);
    chk("arst_bits", 32'(bus.tx_bits), 32'd0);
    chk("arst_ready", 32'(bus.msg_ready), 32'd1);
    chk("arst_wt", 32'(bus.tx_err_weight), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mlfsr = SEED;
    tick();
    ref_rand(pat, steps);
    send(4'hC, 2'b10, 12'h000, lat);
    chk("reseed_pat", 32'(bus.tx_bits ^ bus.tx_clean), 32'(first_pat));
    chk("reseed_clean", 32'(bus.tx_clean), 32'(ref_enc(4'hC)));

    // Back-to-back on the short-hold instance with msg_valid held high
    bus4.msg = 4'h3; bus4.err_mode = 2'b00; bus4.msg_valid = 1'b1;
    hs[0] = -1; hs[1] = -1; nhs = 0; low = 0; between = 12'h000;
    for (int i = 0; i < 12 && nhs < 2; i++) begin
      if (bus4.msg_ready) begin
        hs[nhs] = i;
        if (nhs == 1) between = bus4.tx_bits;
        nhs++;
      end else begin
        low++;
        bus4.msg = 4'h9;
      end
      tick();
    end
    bus4.msg_valid = 1'b0;
    chk("b2b_gap", 32'(hs[1] - hs[0]), 32'd6);
    chk("b2b_ready_low", 32'(low), 32'd5);
    chk("b2b_between", 32'(between), 32'(ref_enc(4'h3)));
    chk("b2b_encode_bits", 32'(bus4.tx_bits), 32'(ref_enc(4'h3)));
    tick();
    chk("b2b_second_clean", 32'(bus4.tx_clean), 32'(ref_enc(4'h9)));
    chk("b2b_second_valid", 32'(bus4.tx_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
